sobel_edge_filter: RTL



---
 rtl/sobel_edge_filter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sobel_edge_filter.sv
// Streaming 3x3 Sobel edge detector: two line buffers feed a 3x3 window,
// gradients are registered, then mode select / saturation / border masking.
module sobel_edge_filter #(
   parameter int IMG_WIDTH = 640,
   parameter int DATA_W    = 12
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iFRAME_START,
   input  logic [DATA_W-1:0] iDATA,
   input  logic              iDVAL,
   input  logic [1:0]        iMODE,
   output logic [DATA_W-1:0] oDATA,
   output logic              oDVAL
);
   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = 11;
   localparam int SUM_W = DATA_W + 2;
   localparam int G_W   = DATA_W + 3;
   localparam int OUT_W = G_W + 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_MAX  = '1;
   localparam logic [OUT_W-1:0] SAT_LIM  = OUT_W'((1 << DATA_W) - 1);

   logic [COL_W-1:0]  col, cur_col;
   logic [ROW_W-1:0]  row, cur_row;
   logic [1:0]        mode_r;

   logic [DATA_W-1:0] lb0 [IMG_WIDTH];
   logic [DATA_W-1:0] lb1 [IMG_WIDTH];
   logic [DATA_W-1:0] lb0_rd, lb1_rd;

   logic [DATA_W-1:0] w [3][3];
   logic              v1, b1;

   logic [SUM_W-1:0]  gx_p, gx_n, gy_p, gy_n;
   logic signed [G_W-1:0] gx, gy;
   logic [G_W-1:0]    gx_abs, gy_abs;

   logic [G_W-1:0]    abs_gx, abs_gy;
   logic [DATA_W-1:0] ctr;
   logic              v2, b2;

   logic [OUT_W-1:0]  sel;
   logic [DATA_W-1:0] sat;

   // A frame start in the same cycle as a pixel makes that pixel (0,0).
   assign cur_col = iFRAME_START ? '0 : col;
   assign cur_row = iFRAME_START ? '0 : row;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         col    <= '0;
         row    <= '0;
         mode_r <= '0;
      end else begin
         if (iFRAME_START) begin
            col    <= '0;
            row    <= '0;
            mode_r <= iMODE;
         end
         if (iDVAL) begin
            if (cur_col == COL_LAST) begin
               col <= '0;
               row <= (cur_row == ROW_MAX) ? cur_row : cur_row + 1'b1;
            end else begin
               col <= cur_col + 1'b1;
               row <= cur_row;
            end
         end
      end
   end

   assign lb0_rd = lb0[cur_col];
   assign lb1_rd = lb1[cur_col];

   // Line-buffer contents are never cleared; border masking hides stale data.
   always_ff @(posedge iCLK) begin
      if (iDVAL) begin
         lb1[cur_col] <= lb0_rd;
         lb0[cur_col] <= iDATA;
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
               w[r][k] <= '0;
         v1 <= 1'b0;
         b1 <= 1'b0;
      end else begin
         if (iDVAL) begin
            for (int r = 0; r < 3; r++) begin
               w[r][0] <= w[r][1];
               w[r][1] <= w[r][2];
            end
            w[0][2] <= lb1_rd;
            w[1][2] <= lb0_rd;
            w[2][2] <= iDATA;
         end
         v1 <= iDVAL;
         b1 <= (cur_row < ROW_W'(2)) || (cur_col < COL_W'(2));
      end
   end

   assign gx_p = SUM_W'(w[0][2]) + SUM_W'({w[1][2], 1'b0}) + SUM_W'(w[2][2]);
   assign gx_n = SUM_W'(w[0][0]) + SUM_W'({w[1][0], 1'b0}) + SUM_W'(w[2][0]);
   assign gy_p = SUM_W'(w[2][0]) + SUM_W'({w[2][1], 1'b0}) + SUM_W'(w[2][2]);
   assign gy_n = SUM_W'(w[0][0]) + SUM_W'({w[0][1], 1'b0}) + SUM_W'(w[0][2]);

   assign gx = $signed(G_W'(gx_p)) - $signed(G_W'(gx_n));
   assign gy = $signed(G_W'(gy_p)) - $signed(G_W'(gy_n));

   assign gx_abs = gx[G_W-1] ? $unsigned(-gx) : $unsigned(gx);
   assign gy_abs = gy[G_W-1] ? $unsigned(-gy) : $unsigned(gy);

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         abs_gx <= '0;
         abs_gy <= '0;
         ctr    <= '0;
         v2     <= 1'b0;
         b2     <= 1'b0;
      end else begin
         abs_gx <= gx_abs;
         abs_gy <= gy_abs;
         ctr    <= w[1][1];
         v2     <= v1;
         b2     <= b1;
      end
   end

   always_comb begin
      sel = '0;
      case (mode_r)
         2'b00:   sel = OUT_W'(ctr);
         2'b01:   sel = OUT_W'(abs_gx);
         2'b10:   sel = OUT_W'(abs_gy);
         default: sel = OUT_W'(abs_gx) + OUT_W'(abs_gy);
      endcase
      sat = (sel > SAT_LIM) ? '1 : sel[DATA_W-1:0];
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         oDATA <= '0;
         oDVAL <= 1'b0;
      end else begin
         oDVAL <= v2;
         if (v2)
            oDATA <= b2 ? '0 : sat;
      end
   end

endmodule
